// File: rtl/mdu_unit_pkg.sv
// MDU opcode encodings shared by the EX stage and the multiply/divide unit.
// Codes 9..15 are undefined and are treated as no-ops.
package mdu_unit_pkg;
  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
endpackage

// File: rtl/mdu_unit.sv
// Multiply/divide unit with HI/LO: result computed at issue, committed after a fixed latency.
// Latency MULT_CYCLES (mult/madd) or DIV_CYCLES (div); MTHI/MTLO take effect at the issue edge.
// No backpressure: starts while busy are dropped, flush aborts. MADD/MADDU enabled by MDU_MADD_EN.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] counter;
  logic [31:0]   tmp_hi;
  logic [31:0]   tmp_lo;
  logic          tmp_wr;

  logic          mul_sgn;
  logic [63:0]   prod;
  logic          div_sgn;
  logic [31:0]   dvd;
  logic [31:0]   dvs;
  logic [31:0]   uq;
  logic [31:0]   ur;
  logic [31:0]   quo;
  logic [31:0]   rem;

  logic          iss_op;
  logic          iss_wr;
  logic [CW-1:0] iss_lat;
  logic [63:0]   iss_res;

  assign busy = (counter != '0);

  // One multiplier: signed forms are sign-extended to 64 bits so the low 64 product bits are exact.
  assign mul_sgn = (MDUop == MDU_MULT) || (MDUop == MDU_MADD);
  assign prod    = {{32{A[31] & mul_sgn}}, A} * {{32{B[31] & mul_sgn}}, B};

  // One unsigned divider on magnitudes; signs restored afterwards, so 0x80000000/-1 wraps cleanly.
  assign div_sgn = (MDUop == MDU_DIV);
  assign dvd     = (div_sgn && A[31]) ? (~A + 32'd1) : A;
  assign dvs     = (div_sgn && B[31]) ? (~B + 32'd1) : B;
  assign uq      = dvd / ((dvs == '0) ? 32'd1 : dvs);
  assign ur      = dvd % ((dvs == '0) ? 32'd1 : dvs);
  assign quo     = (div_sgn && (A[31] ^ B[31])) ? (~uq + 32'd1) : uq;
  assign rem     = (div_sgn && A[31]) ? (~ur + 32'd1) : ur;

  always_comb begin
    iss_op  = 1'b0;
    iss_wr  = 1'b0;
    iss_lat = '0;
    iss_res = '0;
    case (MDUop)
      MDU_MULT, MDU_MULTU: begin
        iss_op  = 1'b1;
        iss_wr  = 1'b1;
        iss_lat = CW'(MULT_CYCLES);
        iss_res = prod;
      end
      MDU_DIV, MDU_DIVU: begin
        iss_op  = 1'b1;
        iss_wr  = (B != '0);
        iss_lat = CW'(DIV_CYCLES);
        iss_res = {rem, quo};
      end
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU: begin
        iss_op  = 1'b1;
        iss_wr  = 1'b1;
        iss_lat = CW'(MULT_CYCLES);
        iss_res = {HI, LO} + prod;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= '0;
      tmp_hi  <= '0;
      tmp_lo  <= '0;
      tmp_wr  <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else if (flush) begin
      counter <= '0;
    end else if (busy) begin
      counter <= counter - CW'(1);
      if (counter == CW'(1) && tmp_wr) begin
        HI <= tmp_hi;
        LO <= tmp_lo;
      end
    end else if (start) begin
      if (iss_op) begin
        counter <= iss_lat;
        tmp_hi  <= iss_res[63:32];
        tmp_lo  <= iss_res[31:0];
        tmp_wr  <= iss_wr;
      end else if (MDUop == MDU_MTHI) begin
        HI <= A;
      end else if (MDUop == MDU_MTLO) begin
        LO <= A;
      end
    end
  end

endmodule
